// File: rtl/vx_perf_memsys_sampler.sv
// Memory-system perf counter sampler: takes an atomic snapshot of all counters
// on a timer fire or manual trigger, then streams it out as a framed
// valid/ready word sequence (header word followed by counter slices).
module vx_perf_memsys_sampler #(
   parameter int unsigned NUM_CTRS    = 22,
   parameter int unsigned CTR_BITS    = 44,
   parameter int unsigned OUT_BITS    = 32,
   parameter int unsigned PERIOD_BITS = 16
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         enable,
   input  logic [PERIOD_BITS-1:0]       period,
   input  logic                         trigger,
   input  logic [NUM_CTRS*CTR_BITS-1:0] ctr_in,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [OUT_BITS-1:0]          out_data,
   output logic                         out_last,
   output logic                         busy,
   output logic [15:0]                  overrun_count
);

   localparam int unsigned WPC      = (CTR_BITS + OUT_BITS - 1) / OUT_BITS;
   localparam int unsigned NDATA    = NUM_CTRS * WPC;
   localparam int unsigned NWORDS   = 1 + NDATA;
   localparam int unsigned IDX_BITS = $clog2(NDATA);

   localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NDATA - 1);
   localparam logic [15:0]         NWORDS16 = 16'(NWORDS);

   typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;

   state_e                         state_q, state_d;
   logic [PERIOD_BITS-1:0]         timer_q, timer_d;
   logic [NUM_CTRS*CTR_BITS-1:0]   shadow_q, shadow_d;
   logic [IDX_BITS-1:0]            widx_q, widx_d;
   logic [15:0]                    seq_q, seq_d;
   logic [15:0]                    ovf_q, ovf_d;

   logic                           fire;
   logic                           req;
   logic                           hs;
   logic [NDATA*OUT_BITS-1:0]      words_flat;

   // Sample timer: free-runs while enabled with a non-zero period, wraps on fire.
   always_comb begin
      fire    = 1'b0;
      timer_d = '0;
      if (enable && (period != '0)) begin
         // A period lowered below the current count fires right away.
         if (timer_q >= period - PERIOD_BITS'(1)) begin
            fire = 1'b1;
         end else begin
            timer_d = timer_q + 1'b1;
         end
      end
   end

   assign req = fire | trigger;
   assign hs  = out_valid & out_ready;

   // Frame sequencing, snapshot capture and overrun accounting.
   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      widx_d   = widx_q;
      seq_d    = seq_q;
      ovf_d    = ovf_q;
      unique case (state_q)
         StIdle: begin
            if (req) begin
               state_d  = StHdr;
               shadow_d = ctr_in;
               widx_d   = '0;
            end
         end
         StHdr: begin
            if (hs) state_d = StData;
         end
         StData: begin
            if (hs) begin
               if (widx_q == LAST_IDX) begin
                  state_d = StIdle;
                  seq_d   = seq_q + 16'd1;
               end else begin
                  widx_d = widx_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      // Any request while a frame is held is dropped, including one that
      // coincides with the final handshake.
      if (req && (state_q != StIdle) && (ovf_q != 16'hFFFF)) begin
         ovf_d = ovf_q + 16'd1;
      end
   end

   // Lay the shadow out as zero-padded stream words, least-significant slice first.
   always_comb begin
      words_flat = '0;
      for (int unsigned k = 0; k < NUM_CTRS; k++) begin
         words_flat[k*WPC*OUT_BITS +: CTR_BITS] = shadow_q[k*CTR_BITS +: CTR_BITS];
      end
   end

   // Stream outputs derive only from registered state, so they hold across stalls.
   always_comb begin
      out_valid     = (state_q != StIdle);
      busy          = (state_q != StIdle);
      out_last      = (state_q == StData) && (widx_q == LAST_IDX);
      overrun_count = ovf_q;
      out_data      = '0;
      if (state_q == StHdr) begin
         out_data[31:16] = seq_q;
         out_data[15:0]  = NWORDS16;
      end else if (state_q == StData) begin
         out_data = words_flat[widx_q*OUT_BITS +: OUT_BITS];
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         timer_q  <= '0;
         shadow_q <= '0;
         widx_q   <= '0;
         seq_q    <= '0;
         ovf_q    <= '0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         shadow_q <= shadow_d;
         widx_q   <= widx_d;
         seq_q    <= seq_d;
         ovf_q    <= ovf_d;
      end
   end

endmodule

// File: tb/tb_vx_perf_memsys_sampler.sv
// Randomized and directed bench for vx_perf_memsys_sampler, checked against a
// queue-based model of the expected word stream.
module tb_vx_perf_memsys_sampler;

   localparam int NC = 22;
   localparam int CB = 44;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             enable;
   logic [15:0]      period;
   logic             trigger;
   logic [NC*CB-1:0] ctr_in;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_data;
   logic             out_last;
   logic             busy;
   logic [15:0]      overrun_count;

   vx_perf_memsys_sampler dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .enable        (enable),
      .period        (period),
      .trigger       (trigger),
      .ctr_in        (ctr_in),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_last      (out_last),
      .busy          (busy),
      .overrun_count (overrun_count)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Model state: pending words of the frame in flight, timer, sequence, overruns.
   logic [31:0] m_q[$];
   int          m_timer;
   int          m_seq;
   int          m_ovf;
   int          cyc;
   logic        prev_valid;
   logic [31:0] obs[$];
   int          hdr_cyc[$];
   logic [31:0] hdr_word[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [31:0] obs_at(input int i);
      if (obs.size() > i) return obs[i];
      return 32'hDEAD_BEEF;
   endfunction

   task automatic model_clear();
      m_q.delete();
      m_timer    = 0;
      m_seq      = 0;
      m_ovf      = 0;
      prev_valid = 1'b0;
   endtask

   task automatic push_frame();
      logic [43:0] c;
      m_q.push_back(32'((m_seq << 16) | 45));
      for (int k = 0; k < NC; k++) begin
         c = ctr_in[k*CB +: CB];
         m_q.push_back(32'(c & 44'hFFFF_FFFF));
         m_q.push_back(32'(c >> 32));
      end
   endtask

   task automatic model_step();
      bit fire, req, busy0;
      fire = 1'b0;
      if (!(enable && period != 16'd0)) begin
         m_timer = 0;
      end else if (m_timer >= int'(period) - 1) begin
         fire    = 1'b1;
         m_timer = 0;
      end else begin
         m_timer++;
      end
      req   = fire || trigger;
      busy0 = (m_q.size() != 0);
      if (busy0 && out_ready) begin
         void'(m_q.pop_front());
         if (m_q.size() == 0) m_seq = (m_seq + 1) % 65536;
      end
      if (req) begin
         if (busy0) begin
            if (m_ovf < 65535) m_ovf++;
         end else begin
            push_frame();
         end
      end
   endtask

   task automatic check_outputs();
      chk("valid", out_valid, m_q.size() != 0);
      chk("busy", busy, m_q.size() != 0);
      chk("overrun", overrun_count, m_ovf);
      if (m_q.size() != 0) begin
         chk("data", out_data, m_q[0]);
         chk("last", out_last, m_q.size() == 1);
      end else begin
         chk("last_idle", out_last, 0);
      end
   endtask

   // One clock: entered and left at a falling edge with inputs already driven.
   task automatic cycle();
      check_outputs();
      if (out_valid && !prev_valid) begin
         hdr_cyc.push_back(cyc);
         hdr_word.push_back(out_data);
      end
      prev_valid = out_valid;
      if (out_valid && out_ready) obs.push_back(out_data);
      model_step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic rand_ctr();
      for (int k = 0; k < NC; k++) ctr_in[k*CB +: CB] = 44'({$urandom(), $urandom()});
   endtask

   task automatic rand_inputs();
      enable    = 1'($urandom());
      period    = 16'($urandom());
      trigger   = 1'($urandom());
      out_ready = 1'($urandom());
      rand_ctr();
   endtask

   task automatic set_pattern_ctr();
      for (int k = 0; k < NC; k++) ctr_in[k*CB +: CB] = 44'hA00_0000_0000 + 44'(k);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      rand_inputs();
      #1;
      model_clear();
      for (int i = 0; i < 3; i++) begin
         chk("rst_valid", out_valid, 0);
         chk("rst_data", out_data, 0);
         chk("rst_last", out_last, 0);
         chk("rst_busy", busy, 0);
         chk("rst_ovf", overrun_count, 0);
         @(negedge clk);
         rand_inputs();
         #1;
      end
      @(negedge clk);
      enable    = 1'b0;
      period    = 16'd0;
      trigger   = 1'b0;
      out_ready = 1'b1;
      reset_n   = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      cyc = 0;
      model_clear();
      @(negedge clk);

      // Reset with random inputs, then idle with enable and trigger low.
      do_reset();
      rand_ctr();
      repeat (20) cycle();

      // Single frame with the ramp pattern.
      set_pattern_ctr();
      obs.delete();
      trigger = 1'b1;
      cycle();
      trigger = 1'b0;
      repeat (55) cycle();
      chk("t2_nwords", obs.size(), 45);
      chk("t2_w0", obs_at(0), 32'h0000_002D);
      chk("t2_w1", obs_at(1), 32'h0000_0000);
      chk("t2_w2", obs_at(2), 32'h0000_0A00);
      chk("t2_w3", obs_at(3), 32'h0000_0001);
      chk("t2_w4", obs_at(4), 32'h0000_0A00);
      chk("t2_w44", obs_at(44), 32'h0000_0A00);

      // Backpressure with counters changing every cycle after capture.
      obs.delete();
      rand_ctr();
      trigger = 1'b1;
      cycle();
      trigger = 1'b0;
      n = 0;
      while (m_q.size() != 0 && n < 2000) begin
         out_ready = ($urandom_range(0, 9) < 3);
         rand_ctr();
         cycle();
         n++;
      end
      chk("t3_timeout", n < 2000, 1);
      out_ready = 1'b1;
      cycle();
      chk("t3_nwords", obs.size(), 45);

      // Periodic sampling at period 100, then timer off.
      do_reset();
      hdr_cyc.delete();
      hdr_word.delete();
      period = 16'd100;
      enable = 1'b1;
      repeat (320) cycle();
      chk("t4_nframes", hdr_cyc.size(), 3);
      for (int i = 0; i < hdr_word.size(); i++) begin
         chk("t4_hdr", hdr_word[i], 32'((i << 16) | 45));
         if (i > 0) chk("t4_spacing", hdr_cyc[i] - hdr_cyc[i-1], 100);
      end
      period = 16'd0;
      hdr_cyc.delete();
      repeat (300) cycle();
      chk("t4_off_frames", hdr_cyc.size(), 0);

      // Trigger coinciding with a timer fire, then triggers mid-frame.
      do_reset();
      hdr_cyc.delete();
      period = 16'd10;
      enable = 1'b1;
      repeat (9) cycle();
      trigger = 1'b1;
      cycle();
      trigger = 1'b0;
      enable  = 1'b0;
      chk("t5_ovf0", overrun_count, 0);
      for (int i = 0; i < 3; i++) begin
         repeat (5) cycle();
         trigger = 1'b1;
         cycle();
         trigger = 1'b0;
      end
      repeat (40) cycle();
      chk("t5_nframes", hdr_cyc.size(), 1);
      chk("t5_ovf3", overrun_count, 3);

      // Randomized traffic.
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if (i % 250 == 0) begin
            enable = 1'($urandom());
            period = 16'($urandom_range(0, 60));
         end
         trigger   = ($urandom_range(0, 99) < 3);
         out_ready = ($urandom_range(0, 9) < 7);
         rand_ctr();
         cycle();
      end

      // Reset in the middle of a frame.
      do_reset();
      set_pattern_ctr();
      trigger = 1'b1;
      cycle();
      trigger = 1'b0;
      repeat (20) cycle();
      chk("t6_mid_valid", out_valid, 1);
      reset_n = 1'b0;
      #1;
      chk("t6_async_valid", out_valid, 0);
      chk("t6_async_busy", busy, 0);
      chk("t6_async_last", out_last, 0);
      model_clear();
      @(negedge clk);
      reset_n = 1'b1;
      obs.delete();
      hdr_word.delete();
      trigger = 1'b1;
      cycle();
      trigger = 1'b0;
      repeat (55) cycle();
      chk("t6_nwords", obs.size(), 45);
      chk("t6_hdr", obs_at(0), 32'h0000_002D);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
